// File: rtl/intr_ctl85_if.sv
// Core-side handshake between the 8085 sequencer and the interrupt controller.
interface intr_ctl85_if #(
  parameter int ADDRSIZE = 16,
  parameter int DATASIZE = 8
);
  logic                ie_set;
  logic                ie_clr;
  logic                sim_wr;
  logic [DATASIZE-1:0] sim_data;
  logic                fetch_bnd;
  logic                ack;
  logic [DATASIZE-1:0] rim_data;
  logic                irq;
  logic                irq_ext;
  logic [ADDRSIZE-1:0] irq_vec;

  modport master (
    output ie_set, ie_clr, sim_wr, sim_data, fetch_bnd, ack,
    input  rim_data, irq, irq_ext, irq_vec
  );

  modport slave (
    input  ie_set, ie_clr, sim_wr, sim_data, fetch_bnd, ack,
    output rim_data, irq, irq_ext, irq_vec
  );
endinterface

// File: rtl/intr_ctl85.sv
// 8085 interrupt priority controller with SIM/RIM registers: pin sync, edge
// latches, masks, delayed EI and a frozen vector handed to the sequencer.
module intr_ctl85 #(
  parameter int ADDRSIZE = 16,
  parameter int DATASIZE = 8,
  parameter int SYNCSTG  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap,
  input  logic        rst75,
  input  logic        rst65,
  input  logic        rst55,
  input  logic        intr,
  input  logic        sid,
  intr_ctl85_if.slave bus,
  output logic        sod
);
  localparam logic [1:0] S_IDLE = 2'd0, S_PEND = 2'd1, S_SERV = 2'd2;
  localparam logic [2:0] SRC_TRAP = 3'd0, SRC_75 = 3'd1, SRC_65 = 3'd2,
                         SRC_55 = 3'd3, SRC_INTR = 3'd4;
  localparam int NP = 6;

  // pin order: {sid, intr, rst55, rst65, rst75, trap}
  logic [SYNCSTG-1:0][NP-1:0] sync_q;
  logic [NP-1:0]              syn;
  logic [1:0]                 prev_q;
  logic                       e_trap, e_75;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNCSTG-2:0], {sid, intr, rst55, rst65, rst75, trap}};
      prev_q <= syn[1:0];
    end
  end

  assign syn    = sync_q[SYNCSTG-1];
  assign e_trap = syn[0] & ~prev_q[0];
  assign e_75   = syn[1] & ~prev_q[1];

  logic [1:0]          state_q, state_d;
  logic                irq_q, irq_d, ext_q, ext_d;
  logic [ADDRSIZE-1:0] vec_q, vec_d;
  logic [2:0]          src_q, src_d;
  logic                ie_q, ie_d, ie_pend_q, ie_pend_d, ie_arm_q, ie_arm_d;
  logic [2:0]          mask_q, mask_d;
  logic                sod_q, sod_d, l75_q, l75_d, ltrap_q, ltrap_d;
  logic                rq_trap, rq_75, rq_65, rq_55, rq_int;
  logic                svc, clr_75, clr_trap;
  logic                unused_sim;

  assign rq_trap = ltrap_q & syn[0];
  assign rq_75   = l75_q  & ~mask_q[2] & ie_q;
  assign rq_65   = syn[2] & ~mask_q[1] & ie_q;
  assign rq_55   = syn[3] & ~mask_q[0] & ie_q;
  assign rq_int  = syn[4] & ie_q;

  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    ext_d     = ext_q;
    vec_d     = vec_q;
    src_d     = src_q;
    ie_d      = ie_q;
    ie_pend_d = ie_pend_q;
    ie_arm_d  = ie_arm_q;
    mask_d    = mask_q;
    sod_d     = sod_q;
    l75_d     = l75_q;
    ltrap_d   = ltrap_q;
    svc       = 1'b0;
    clr_75    = 1'b0;
    clr_trap  = 1'b0;

    case (state_q)
      S_IDLE: if (bus.fetch_bnd) begin
        irq_d   = 1'b1;
        ext_d   = 1'b0;
        state_d = S_PEND;
        if      (rq_trap) begin src_d = SRC_TRAP; vec_d = ADDRSIZE'(16'h0024); end
        else if (rq_75)   begin src_d = SRC_75;   vec_d = ADDRSIZE'(16'h003C); end
        else if (rq_65)   begin src_d = SRC_65;   vec_d = ADDRSIZE'(16'h0034); end
        else if (rq_55)   begin src_d = SRC_55;   vec_d = ADDRSIZE'(16'h002C); end
        else if (rq_int)  begin src_d = SRC_INTR; vec_d = '0; ext_d = 1'b1; end
        else begin
          irq_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      // service bookkeeping is committed on the ack edge so irq drops at once
      S_PEND: if (bus.ack) begin
        state_d  = S_SERV;
        irq_d    = 1'b0;
        ext_d    = 1'b0;
        svc      = 1'b1;
        clr_75   = (src_q == SRC_75);
        clr_trap = (src_q == SRC_TRAP);
      end
      S_SERV:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // EI takes effect on the second fetch boundary, after that cycle's evaluation
    if (bus.fetch_bnd && ie_pend_q) begin
      if (ie_arm_q) begin
        ie_d      = 1'b1;
        ie_pend_d = 1'b0;
        ie_arm_d  = 1'b0;
      end else begin
        ie_arm_d = 1'b1;
      end
    end
    if (bus.ie_set) begin
      ie_pend_d = 1'b1;
      ie_arm_d  = 1'b0;
    end
    if (bus.ie_clr || svc) begin
      ie_d      = 1'b0;
      ie_pend_d = 1'b0;
      ie_arm_d  = 1'b0;
    end

    if (bus.sim_wr) begin
      if (bus.sim_data[3]) mask_d = bus.sim_data[2:0];
      if (bus.sim_data[6]) sod_d  = bus.sim_data[7];
      if (bus.sim_data[4]) clr_75 = 1'b1;
    end

    // a fresh edge beats any clear in the same cycle
    if (clr_75)   l75_d   = 1'b0;
    if (clr_trap) ltrap_d = 1'b0;
    if (e_75)     l75_d   = 1'b1;
    if (e_trap)   ltrap_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      irq_q     <= 1'b0;
      ext_q     <= 1'b0;
      vec_q     <= '0;
      src_q     <= SRC_TRAP;
      ie_q      <= 1'b0;
      ie_pend_q <= 1'b0;
      ie_arm_q  <= 1'b0;
      mask_q    <= 3'b111;
      sod_q     <= 1'b0;
      l75_q     <= 1'b0;
      ltrap_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      ext_q     <= ext_d;
      vec_q     <= vec_d;
      src_q     <= src_d;
      ie_q      <= ie_d;
      ie_pend_q <= ie_pend_d;
      ie_arm_q  <= ie_arm_d;
      mask_q    <= mask_d;
      sod_q     <= sod_d;
      l75_q     <= l75_d;
      ltrap_q   <= ltrap_d;
    end
  end

  always_comb begin
    bus.rim_data      = '0;
    bus.rim_data[7:0] = {syn[5], l75_q, syn[2], syn[3], ie_q, mask_q};
  end

  assign bus.irq     = irq_q;
  assign bus.irq_ext = ext_q;
  assign bus.irq_vec = vec_q;
  assign sod         = sod_q;
  assign unused_sim  = ^bus.sim_data;
endmodule

// File: tb/tb_intr_ctl85.sv
// Scoreboard bench for intr_ctl85: directed scenarios then random traffic,
// checked against a pin-delay-line reference model.
module tb_intr_ctl85;
  localparam int AW = 16, DW = 8, SS = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic trap = 0, rst75 = 0, rst65 = 0, rst55 = 0, intr = 0, sid = 0;
  logic sod;

  intr_ctl85_if #(.ADDRSIZE(AW), .DATASIZE(DW)) bus ();

  intr_ctl85 #(.ADDRSIZE(AW), .DATASIZE(DW), .SYNCSTG(SS)) dut (
    .clk(clk), .rst(rst), .trap(trap), .rst75(rst75), .rst65(rst65),
    .rst55(rst55), .intr(intr), .sid(sid), .bus(bus.slave), .sod(sod)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model
  typedef struct packed { logic [15:0] vec; logic ext; } exp_t;
  exp_t       sbq[$];
  logic [5:0] ph[$];
  bit         m_ie, m_l75, m_ltrap, m_sod, m_pend, m_serv;
  bit   [2:0] m_mask;
  int         m_ei, m_src;
  logic [5:0] ms, mp;
  bit         me75, metr, mc75, mctr, mcie;

  function automatic logic [5:0] msyn();
    if (ph.size() >= SS) return ph[ph.size()-SS];
    return '0;
  endfunction

  function automatic logic [5:0] mprev();
    if (ph.size() >= SS+1) return ph[ph.size()-SS-1];
    return '0;
  endfunction

  function automatic logic [7:0] mrim();
    logic [5:0] s;
    s = msyn();
    return {s[5], m_l75, s[2], s[3], m_ie, m_mask};
  endfunction

  task automatic grant(input logic [15:0] v, input logic x, input int src);
    sbq.push_back({v, x});
    m_pend = 1;
    m_src  = src;
  endtask

  task automatic model_step();
    if (rst) begin
      m_ie = 0; m_ei = 0; m_l75 = 0; m_ltrap = 0; m_sod = 0;
      m_pend = 0; m_serv = 0; m_mask = 3'b111; m_src = 0;
      ph.delete(); sbq.delete();
      return;
    end
    ms = msyn(); mp = mprev();
    me75 = ms[1] && !mp[1];
    metr = ms[0] && !mp[0];
    mc75 = 0; mctr = 0; mcie = 0;
    if (m_serv) m_serv = 0;
    else if (m_pend) begin
      if (bus.ack) begin
        m_pend = 0; m_serv = 1; mcie = 1;
        mc75 = (m_src == 1); mctr = (m_src == 0);
      end
    end else if (bus.fetch_bnd) begin
      if      (m_ltrap && ms[0])              grant(16'h0024, 1'b0, 0);
      else if (m_ie && m_l75 && !m_mask[2])   grant(16'h003C, 1'b0, 1);
      else if (m_ie && ms[2] && !m_mask[1])   grant(16'h0034, 1'b0, 2);
      else if (m_ie && ms[3] && !m_mask[0])   grant(16'h002C, 1'b0, 3);
      else if (m_ie && ms[4])                 grant(16'h0000, 1'b1, 4);
    end
    if (bus.fetch_bnd && m_ei > 0) begin
      m_ei--;
      if (m_ei == 0) m_ie = 1;
    end
    if (bus.ie_set) m_ei = 2;
    if (bus.ie_clr || mcie) begin m_ie = 0; m_ei = 0; end
    if (bus.sim_wr) begin
      if (bus.sim_data[3]) m_mask = bus.sim_data[2:0];
      if (bus.sim_data[6]) m_sod  = bus.sim_data[7];
      if (bus.sim_data[4]) mc75   = 1;
    end
    if (mc75) m_l75   = 0;
    if (mctr) m_ltrap = 0;
    if (me75) m_l75   = 1;
    if (metr) m_ltrap = 1;
    ph.push_back({sid, intr, rst55, rst65, rst75, trap});
    if (ph.size() > SS+1) void'(ph.pop_front());
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // monitor
  logic last_irq = 0;
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (rst) last_irq = 0;
    else begin
      chk("irq_lvl", bus.irq, m_pend);
      chk("rim", bus.rim_data, mrim());
      chk("sod", sod, m_sod);
      if (!bus.irq) chk("ext_idle", bus.irq_ext, 0);
      if (bus.irq && !last_irq) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL irq_unexp: irq=1 vec=%0h, none expected at %0t", bus.irq_vec, $time);
        end else begin
          e = sbq.pop_front();
          chk("vec", bus.irq_vec, e.vec);
          chk("ext", bus.irq_ext, e.ext);
        end
      end
      last_irq = bus.irq;
    end
  end

  // stimulus helpers
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic sim(input logic [7:0] d);
    bus.sim_wr = 1; bus.sim_data = d; @(negedge clk); bus.sim_wr = 0;
  endtask
  task automatic fetch();
    bus.fetch_bnd = 1; @(negedge clk); bus.fetch_bnd = 0;
  endtask
  task automatic do_ack();
    bus.ack = 1; @(negedge clk); bus.ack = 0;
  endtask
  task automatic do_ei();
    bus.ie_set = 1; @(negedge clk); bus.ie_set = 0;
    fetch(); fetch();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  logic [7:0] r;
  initial begin
    bus.ie_set = 0; bus.ie_clr = 0; bus.sim_wr = 0; bus.sim_data = 0;
    bus.fetch_bnd = 0; bus.ack = 0;
    wait_n(3);
    rst = 0;
    wait_n(3);
    chk("rst_irq", bus.irq, 0);
    chk("rst_rim", bus.rim_data, 8'h07);
    chk("rst_sod", sod, 0);
    sim(8'hC8);
    chk("sim_rim", bus.rim_data, 8'h00);
    chk("sim_sod", sod, 1);

    // delayed EI, then RST6.5
    sim(8'h08);
    do_ei();
    rst65 = 1;
    fetch();
    chk("r65_early", bus.irq, 0);
    wait_n(SS+1);
    fetch();
    chk("r65_irq", bus.irq, 1);
    chk("r65_vec", bus.irq_vec, 16'h0034);
    chk("r65_ext", bus.irq_ext, 0);
    do_ack();
    chk("r65_ack", bus.irq, 0);
    r = bus.rim_data;
    chk("r65_ie", r[3], 0);
    wait_n(2);

    // priority among 7.5 / 6.5 / 5.5
    do_ei();
    rst55 = 1; rst75 = 1;
    wait_n(1);
    rst75 = 0;
    wait_n(SS+2);
    fetch();
    chk("p75_vec", bus.irq_vec, 16'h003C);
    do_ack(); wait_n(1);
    do_ei(); fetch();
    chk("p65_vec", bus.irq_vec, 16'h0034);
    do_ack(); wait_n(1);
    rst65 = 0;
    do_ei(); wait_n(SS+1); fetch();
    chk("p55_vec", bus.irq_vec, 16'h002C);
    do_ack(); wait_n(1);
    rst55 = 0;

    // TRAP with ie=0, then a short trap pulse
    trap = 1;
    wait_n(SS+2);
    fetch();
    chk("trap_irq", bus.irq, 1);
    chk("trap_vec", bus.irq_vec, 16'h0024);
    do_ack(); wait_n(1);
    trap = 0; wait_n(SS+2);
    trap = 1; wait_n(1); trap = 0;
    wait_n(SS+3);
    fetch();
    chk("trap_short", bus.irq, 0);

    // masked RST7.5 and R7.5 clear
    sim(8'h0C);
    do_ei();
    rst75 = 1; wait_n(1); rst75 = 0;
    wait_n(SS+2);
    r = bus.rim_data;
    chk("m75_pend", r[6], 1);
    fetch();
    chk("m75_noirq", bus.irq, 0);
    sim(8'h10);
    r = bus.rim_data;
    chk("r75_clr", r[6], 0);
    rst75 = 1;
    wait_n(SS);
    sim(8'h10);
    r = bus.rim_data;
    chk("r75_race", r[6], 1);
    rst75 = 0;
    sim(8'h10);

    // INTR, held through withdrawal, then async reset in PEND
    sim(8'h08);
    intr = 1;
    wait_n(SS+1);
    fetch();
    chk("intr_ext", bus.irq_ext, 1);
    chk("intr_vec", bus.irq_vec, 16'h0000);
    intr = 0;
    wait_n(SS+3);
    chk("intr_hold", bus.irq, 1);
    #2 rst = 1;
    #1;
    chk("rst_pend_irq", bus.irq, 0);
    chk("rst_pend_ext", bus.irq_ext, 0);
    chk("rst_pend_vec", bus.irq_vec, 16'h0000);
    @(negedge clk);
    rst = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  trap  = ~trap;
      if ($urandom_range(0, 5) == 0)  rst75 = ~rst75;
      if ($urandom_range(0, 7) == 0)  rst65 = ~rst65;
      if ($urandom_range(0, 7) == 0)  rst55 = ~rst55;
      if ($urandom_range(0, 7) == 0)  intr  = ~intr;
      if ($urandom_range(0, 3) == 0)  sid   = ~sid;
      bus.ie_set    = ($urandom_range(0, 15) == 0);
      bus.ie_clr    = ($urandom_range(0, 39) == 0);
      bus.sim_wr    = ($urandom_range(0, 19) == 0);
      bus.sim_data  = 8'($urandom);
      bus.fetch_bnd = ($urandom_range(0, 2) == 0);
      bus.ack       = m_pend && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    bus.ie_set = 0; bus.ie_clr = 0; bus.sim_wr = 0; bus.fetch_bnd = 0; bus.ack = 0;
    wait_n(2);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
